romulus_stream_seq: RTL and testbench

- Control-only sequencer between a command/stream interface and the masked Romulus-N `cipher` core.
- Per message: accepts a byte-length command, issues `start`, meters plaintext blocks with correct `plaintext_nbytes`, and counts ciphertext blocks. It asserts `ciphertext_last`, waits for `finish`, then presents the tag.
- Data buses (plaintext, ciphertext, tag, nonce, key, tweaks, masked init state, randomness) connect directly between user logic and the cipher. This block drives only handshakes and lengths.

---
 rtl/romulus_seq_pkg.sv | 24 ++
 rtl/seq_len_slicer.sv | 25 ++
 rtl/romulus_stream_seq.sv | 161 ++++++++++++++++
 tb/tb_romulus_stream_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_seq_pkg.sv
// Shared types and helpers for the Romulus-N stream sequencer.
// Holds the FSM state encoding and block-count arithmetic.
package romulus_seq_pkg;

    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned NB_W      = BLK_BYTES + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_DRAIN,
        S_TAG
    } seq_state_e;

    // An empty message still occupies one (empty) cipher block.
    function automatic int unsigned ceil_blocks(input int unsigned len,
                                                input int unsigned blk_bytes = BLK_BYTES);
        int unsigned n;
        n = (len + blk_bytes - 1) / blk_bytes;
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/seq_len_slicer.sv
// Combinational length slicing: bytes in the current block and total block count.
// Kept separate so an associated-data sequencer can reuse it.
module seq_len_slicer
    import romulus_seq_pkg::*;
#(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned BLK_BYTES_P = BLK_BYTES,
    parameter int unsigned NB_WIDTH    = NB_W
) (
    input  logic [LEN_W-1:0]    bytes_rem_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic [NB_WIDTH-1:0] nbytes_o,
    output logic [LEN_W-1:0]    blocks_o
);

    always_comb begin
        if (32'(bytes_rem_i) >= BLK_BYTES_P) begin
            nbytes_o = NB_WIDTH'(BLK_BYTES_P);
        end else begin
            nbytes_o = NB_WIDTH'(bytes_rem_i);
        end
        blocks_o = LEN_W'(ceil_blocks(32'(len_i), BLK_BYTES_P));
    end

endmodule

// File: rtl/romulus_stream_seq.sv
// Handshake/length sequencer for the masked Romulus-N cipher core.
// Optional cycle counter port enabled by defining ROMULUS_SEQ_CYCLE_COUNT_EN.
module romulus_stream_seq
    import romulus_seq_pkg::*;
#(
    parameter int unsigned BLK_SIZE = 128,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  tag_valid,
    input  logic                  tag_ready,
    output logic                  c_start,
    output logic [BLK_SIZE/8:0]   c_pt_nbytes,
    output logic                  c_pt_valid,
    input  logic                  c_pt_ready,
    input  logic                  c_ct_valid,
    output logic                  c_ct_ready,
    output logic                  c_ct_last,
    input  logic                  c_finish
`ifdef ROMULUS_SEQ_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0]      cyc_count
`endif
);

    localparam int unsigned BB = BLK_SIZE / 8;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] bytes_rem_q, bytes_rem_d;
    logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
    logic             fin_seen_q, fin_seen_d;

    logic [BB:0]      nbytes;
    logic [LEN_W-1:0] blocks;
    logic             in_phase, out_phase, pt_fire, ct_fire;

    seq_len_slicer #(
        .LEN_W       (LEN_W),
        .BLK_BYTES_P (BB),
        .NB_WIDTH    (BB + 1)
    ) u_slicer (
        .bytes_rem_i (bytes_rem_q),
        .len_i       (cmd_len),
        .nbytes_o    (nbytes),
        .blocks_o    (blocks)
    );

    assign in_phase  = (state_q == S_FEED);
    assign out_phase = (state_q == S_FEED) || (state_q == S_DRAIN);

    // Gating with rst keeps every output low while reset is held.
    assign cmd_ready   = (state_q == S_IDLE) && !rst;
    assign c_start     = (state_q == S_START);
    assign c_pt_valid  = in_phase && din_valid;
    assign din_ready   = in_phase && c_pt_ready;
    assign c_pt_nbytes = in_phase ? nbytes : '0;
    assign dout_valid  = out_phase && c_ct_valid;
    assign c_ct_ready  = out_phase && dout_ready;
    assign dout_last   = dout_valid && (out_cnt_q == LEN_W'(1));
    assign c_ct_last   = (out_phase || (state_q == S_TAG)) && (in_cnt_q == '0);
    assign tag_valid   = (state_q == S_TAG);

    assign pt_fire = c_pt_valid && c_pt_ready;
    assign ct_fire = dout_valid && dout_ready;

    always_comb begin
        state_d     = state_q;
        bytes_rem_d = bytes_rem_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        fin_seen_d  = fin_seen_q;

        if (ct_fire && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - LEN_W'(1);
        end
        if ((state_q != S_IDLE) && c_finish) begin
            fin_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    bytes_rem_d = cmd_len;
                    in_cnt_d    = blocks;
                    out_cnt_d   = blocks;
                    fin_seen_d  = 1'b0;
                    state_d     = S_START;
                end
            end
            S_START: state_d = S_FEED;
            S_FEED: begin
                if (pt_fire) begin
                    bytes_rem_d = bytes_rem_q - LEN_W'(nbytes);
                    in_cnt_d    = in_cnt_q - LEN_W'(1);
                    if (in_cnt_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((in_cnt_q == '0) && (out_cnt_q == '0) && (fin_seen_q || c_finish)) begin
                    state_d = S_TAG;
                end
            end
            S_TAG: begin
                if (tag_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bytes_rem_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            fin_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bytes_rem_q <= bytes_rem_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            fin_seen_q  <= fin_seen_d;
        end
    end

`ifdef ROMULUS_SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else if ((state_q == S_IDLE) && cmd_valid) begin
            cyc_q <= '0;
        end else if ((state_q != S_IDLE) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + CNT_W'(1);
        end
    end

    assign cyc_count = cyc_q;
`endif

endmodule

// File: tb/tb_romulus_stream_seq.sv
// Scoreboard bench for romulus_stream_seq with a simple cipher-core stand-in.
// Define ROMULUS_SEQ_CYCLE_COUNT_EN to also exercise the cycle counter.
module tb_romulus_stream_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_len;
    logic        din_valid, din_ready;
    logic        dout_valid, dout_ready, dout_last;
    logic        tag_valid, tag_ready;
    logic        c_start;
    logic [16:0] c_pt_nbytes;
    logic        c_pt_valid, c_pt_ready;
    logic        c_ct_valid, c_ct_ready, c_ct_last;
    logic        c_finish;
`ifdef ROMULUS_SEQ_CYCLE_COUNT_EN
    logic [31:0] cyc_count;
`endif

    always #5 clk = ~clk;

    romulus_stream_seq #(
        .BLK_SIZE (128),
        .LEN_W    (16),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .tag_valid   (tag_valid),
        .tag_ready   (tag_ready),
        .c_start     (c_start),
        .c_pt_nbytes (c_pt_nbytes),
        .c_pt_valid  (c_pt_valid),
        .c_pt_ready  (c_pt_ready),
        .c_ct_valid  (c_ct_valid),
        .c_ct_ready  (c_ct_ready),
        .c_ct_last   (c_ct_last),
        .c_finish    (c_finish)
`ifdef ROMULUS_SEQ_CYCLE_COUNT_EN
        ,
        .cyc_count   (cyc_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Cipher stand-in: one ciphertext block becomes available per accepted plaintext block.
    int pend;
    always @(posedge clk or posedge rst) begin
        if (rst) pend <= 0;
        else     pend <= pend + ((c_pt_valid && c_pt_ready) ? 1 : 0)
                              - ((c_ct_valid && c_ct_ready) ? 1 : 0);
    end
    assign c_ct_valid = (pend > 0);

    // Scoreboard queues and monitor.
    int exp_nb[$];
    bit exp_last[$];
    int pt_seen, ct_seen, starts, bench_cyc;

    always @(negedge clk) begin
        if (!rst) begin
            if (c_start) starts++;
            if (!cmd_ready) bench_cyc++;
            if (c_pt_valid && c_pt_ready) begin
                pt_seen++;
                checks++;
                if (exp_nb.size() == 0) begin
                    errors++;
                    $display("FAIL pt_extra actual=nbytes %0d required=no block", c_pt_nbytes);
                end else begin
                    checks--;
                    chk("pt_nbytes", 32'(c_pt_nbytes), 32'(exp_nb.pop_front()));
                end
            end
            if (dout_valid && dout_ready) begin
                ct_seen++;
                checks++;
                if (exp_last.size() == 0) begin
                    errors++;
                    $display("FAIL ct_extra actual=extra block required=none");
                end else begin
                    checks--;
                    chk("dout_last", 32'(dout_last), 32'(exp_last.pop_front()));
                end
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({cmd_ready, din_ready, dout_valid, dout_last, tag_valid,
                    c_start, c_pt_valid, c_ct_ready, c_ct_last, c_pt_nbytes});
    endfunction

    task automatic start_cmd(input int len);
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        bench_cyc = 0;
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("c_start_latency", 32'(c_start), 1);
        chk("cmd_ready_busy", 32'(cmd_ready), 0);
        chk("c_ct_last_start", 32'(c_ct_last), 0);
    endtask

    task automatic run_msg(input int len, input int nblk, input int nb0, input int nb1, input int nb2,
                           input int stall_out, input int stall_in, input bit early_fin,
                           input bit busy, input int tag_delay);
        int nbs[3];
        int cyc;
        int t;
        nbs = '{nb0, nb1, nb2};
        for (int i = 0; i < nblk; i++) begin
            exp_nb.push_back(nbs[i]);
            exp_last.push_back(i == nblk - 1);
        end
        pt_seen = 0; ct_seen = 0; starts = 0;
        start_cmd(len);
        cyc = 0;
        while (ct_seen < nblk && cyc < 1000) begin
            din_valid  = !(cyc >= 2 && cyc < 2 + stall_in);
            dout_ready = (cyc >= stall_out);
            c_finish   = early_fin && (cyc == stall_out - 5);
            cmd_valid  = busy && cyc >= 1 && cyc < 4;
            if (busy && cyc >= 1 && cyc < 4) chk("busy_cmd_ready", 32'(cmd_ready), 0);
            if (pt_seen < nblk) chk("c_ct_last_low", 32'(c_ct_last), 0);
            else                chk("c_ct_last_high", 32'(c_ct_last), 1);
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 1000) chk("ct_timeout", 32'(cyc), 0);
        din_valid = 1'b0; dout_ready = 1'b1; cmd_valid = 1'b0; c_finish = 1'b0;
        chk("pt_count", 32'(pt_seen), 32'(nblk));
        chk("ct_count", 32'(ct_seen), 32'(nblk));
        chk("c_ct_last_drain", 32'(c_ct_last), 1);
        chk("tag_after_drain", 32'(tag_valid), 0);
        if (!early_fin) begin
            @(posedge clk); #1;
            chk("tag_wait_finish", 32'(tag_valid), 0);
            c_finish = 1'b1;
            @(posedge clk); #1;
            c_finish = 1'b0;
        end
        t = 0;
        while (!tag_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("tag_valid", 32'(tag_valid), 1);
        chk("c_ct_last_tag", 32'(c_ct_last), 1);
        for (int i = 0; i < tag_delay; i++) begin
            @(posedge clk); #1;
            chk("tag_hold", 32'(tag_valid), 1);
        end
        tag_ready = 1'b1;
        @(posedge clk); #1;
        tag_ready = 1'b0;
        chk("cmd_ready_after_tag", 32'(cmd_ready), 1);
        chk("tag_valid_clear", 32'(tag_valid), 0);
        chk("c_ct_last_clear", 32'(c_ct_last), 0);
        chk("start_once", 32'(starts), 1);
        chk("exp_left", 32'(exp_nb.size() + exp_last.size()), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_len = '0;
        din_valid = 1'b0; dout_ready = 1'b1; tag_ready = 1'b0;
        c_pt_ready = 1'b1; c_finish = 1'b0;
        #1;
        chk("reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs", all_outs(), 32'h0200_0000);

        run_msg(32, 2, 16, 16, 0,  0,  0, 1'b0, 1'b1, 0);
        run_msg(20, 2, 16,  4, 0,  0,  0, 1'b0, 1'b0, 1);
        run_msg( 0, 1,  0,  0, 0,  0,  0, 1'b0, 1'b0, 0);
        run_msg(48, 3, 16, 16, 16, 50, 30, 1'b1, 1'b0, 2);

        // Abort mid-message with one plaintext block outstanding.
        exp_nb.push_back(16); exp_nb.push_back(16);
        exp_last.push_back(1'b0); exp_last.push_back(1'b1);
        pt_seen = 0;
        start_cmd(32);
        din_valid = 1'b1;
        for (int i = 0; i < 20 && pt_seen < 1; i++) begin
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        chk("abort_pt_seen", 32'(pt_seen), 1);
        rst = 1'b1;
        #1;
        chk("abort_outputs", all_outs(), 0);
        exp_nb.delete(); exp_last.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        run_msg(16, 1, 16, 0, 0, 0, 0, 1'b0, 1'b0, 0);

`ifdef ROMULUS_SEQ_CYCLE_COUNT_EN
        run_msg(16, 1, 16, 0, 0, 0, 0, 1'b0, 1'b0, 3);
        chk("cyc_count", cyc_count, 32'(bench_cyc));
        repeat (3) @(posedge clk);
        #1;
        chk("cyc_count_hold", cyc_count, 32'(bench_cyc));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
